// File: rtl/hack_mem_bus.sv
// Parametrised address-window bus fabric for hack_cpu: decodes NUM_REGIONS windows,
// qualifies write strobes, returns read data one cycle later and logs write errors.
module hack_mem_bus #(
  parameter int                           WIDTH       = 16,
  parameter int                           NUM_REGIONS = 3,
  parameter logic [NUM_REGIONS*WIDTH-1:0] REGION_BASE = {16'd24576, 16'd16384, 16'd0},
  parameter logic [NUM_REGIONS*WIDTH-1:0] REGION_END  = {16'd24577, 16'd24576, 16'd16384},
  parameter logic [NUM_REGIONS-1:0]       REGION_RO   = 3'b100,
  parameter int                           CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             addressM,
  input  logic [WIDTH-1:0]             outM,
  input  logic                         writeM,
  output logic [WIDTH-1:0]             inM,
  output logic [WIDTH-1:0]             region_addr,
  output logic [WIDTH-1:0]             region_wdata,
  output logic [NUM_REGIONS-1:0]       region_write,
  input  logic [NUM_REGIONS*WIDTH-1:0] region_rdata,
  output logic                         invalid_addressM,
  input  logic                         err_clear,
  output logic                         err_valid,
  output logic [1:0]                   err_code,
  output logic [WIDTH-1:0]             err_addr,
  output logic [CNT_W-1:0]             err_count
);

  if (NUM_REGIONS < 1 || NUM_REGIONS > 8) begin : g_bad_num_regions
    $error("hack_mem_bus: NUM_REGIONS must be in 1..8");
  end

  localparam logic [1:0] CODE_UNMAPPED = 2'd1;
  localparam logic [1:0] CODE_RO_WRITE = 2'd2;

  function automatic logic [WIDTH-1:0] base_of(input int idx);
    return REGION_BASE[idx*WIDTH +: WIDTH];
  endfunction

  // An empty or inverted window (base >= end) can never satisfy both bounds.
  function automatic logic in_window(input logic [WIDTH-1:0] addr, input int idx);
    return (addr >= base_of(idx)) && (addr < REGION_END[idx*WIDTH +: WIDTH]);
  endfunction

  logic [NUM_REGIONS-1:0] hit_s;
  logic [NUM_REGIONS-1:0] sel_r;
  logic [WIDTH-1:0]       region_addr_s;
  logic [WIDTH-1:0]       rdata_mux_s;
  logic                   ro_hit_s;
  logic                   err_event_s;
  logic [1:0]             err_code_ev_s;
  logic                   err_valid_r;
  logic [1:0]             err_code_r;
  logic [WIDTH-1:0]       err_addr_r;
  logic [CNT_W-1:0]       err_count_r;

  // Priority decode: the lowest-index matching window owns the address.
  always_comb begin
    logic taken;
    hit_s = '0;
    taken = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!taken && in_window(addressM, i)) begin
        hit_s[i] = 1'b1;
        taken    = 1'b1;
      end else begin
        hit_s[i] = 1'b0;
      end
    end
  end

  // Region-relative address of the winning window.
  always_comb begin
    region_addr_s = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (hit_s[i]) begin
        region_addr_s = addressM - base_of(i);
      end else begin
        region_addr_s = region_addr_s;
      end
    end
  end

  // Error classification for the current cycle.
  always_comb begin
    ro_hit_s      = |(hit_s & REGION_RO);
    err_event_s   = writeM & (invalid_addressM | ro_hit_s);
    err_code_ev_s = invalid_addressM ? CODE_UNMAPPED : CODE_RO_WRITE;
  end

  // Read return mux driven by last cycle's registered selection.
  always_comb begin
    rdata_mux_s = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      rdata_mux_s = rdata_mux_s | ({WIDTH{sel_r[i]}} & region_rdata[i*WIDTH +: WIDTH]);
    end
  end

  // Read select register matching synchronous RAM latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_r <= '0;
    end else begin
      sel_r <= hit_s;
    end
  end

  // Sticky error capture; a new event in the clear cycle restarts the log with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_valid_r <= 1'b0;
      err_code_r  <= 2'd0;
      err_addr_r  <= '0;
      err_count_r <= '0;
    end else if (err_clear) begin
      if (err_event_s) begin
        err_valid_r <= 1'b1;
        err_code_r  <= err_code_ev_s;
        err_addr_r  <= addressM;
        err_count_r <= CNT_W'(1);
      end else begin
        err_valid_r <= 1'b0;
        err_code_r  <= 2'd0;
        err_addr_r  <= '0;
        err_count_r <= '0;
      end
    end else if (err_event_s) begin
      if (!err_valid_r) begin
        err_valid_r <= 1'b1;
        err_code_r  <= err_code_ev_s;
        err_addr_r  <= addressM;
      end else begin
        err_valid_r <= err_valid_r;
      end
      if (err_count_r != {CNT_W{1'b1}}) begin
        err_count_r <= err_count_r + CNT_W'(1);
      end else begin
        err_count_r <= err_count_r;
      end
    end else begin
      err_valid_r <= err_valid_r;
    end
  end

  assign invalid_addressM = ~|hit_s;
  assign region_addr      = region_addr_s;
  assign region_wdata     = outM;
  assign region_write     = {NUM_REGIONS{writeM}} & hit_s & ~REGION_RO;
  assign inM              = rdata_mux_s;
  assign err_valid        = err_valid_r;
  assign err_code         = err_code_r;
  assign err_addr         = err_addr_r;
  assign err_count        = err_count_r;

endmodule

// File: tb/tb_hack_mem_bus.sv
// Scoreboard bench for hack_mem_bus: stimulus queues expected values tagged with the
// cycle they are due; a negedge monitor pops and compares them against the DUT.
module tb_hack_mem_bus;

  typedef enum int {S_INM, S_RADDR, S_RWRITE, S_INV, S_EVALID, S_ECODE, S_EADDR, S_ECNT} sig_e;

  typedef struct {
    int          due;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [15:0] region_addr;
  logic [15:0] region_wdata;
  logic [2:0]  region_write;
  logic [47:0] region_rdata;
  logic        invalid_addressM;
  logic        err_clear;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] err_addr;
  logic [7:0]  err_count;

  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];

  hack_mem_bus dut (
    .clk              (clk),
    .reset            (reset),
    .addressM         (addressM),
    .outM             (outM),
    .writeM           (writeM),
    .inM              (inM),
    .region_addr      (region_addr),
    .region_wdata     (region_wdata),
    .region_write     (region_write),
    .region_rdata     (region_rdata),
    .invalid_addressM (invalid_addressM),
    .err_clear        (err_clear),
    .err_valid        (err_valid),
    .err_code         (err_code),
    .err_addr         (err_addr),
    .err_count        (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input sig_e s);
    case (s)
      S_INM:    return {16'd0, inM};
      S_RADDR:  return {16'd0, region_addr};
      S_RWRITE: return {29'd0, region_write};
      S_INV:    return {31'd0, invalid_addressM};
      S_EVALID: return {31'd0, err_valid};
      S_ECODE:  return {30'd0, err_code};
      S_EADDR:  return {16'd0, err_addr};
      S_ECNT:   return {24'd0, err_count};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every entry due in this cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t keep[$];
    logic [31:0] a;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due == cyc) begin
        a = actual(sb[i].sig);
        n_total++;
        if (a === sb[i].val) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h expected %h", sb[i].name, cyc, a, sb[i].val);
      end else if (sb[i].due < cyc) begin
        n_total++;
        $display("FAIL %s: expectation for cycle %0d never checked", sb[i].name, sb[i].due);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic expect_at(input int off, input sig_e s, input logic [31:0] v, input string n);
    sb.push_back('{cyc + off, s, v, n});
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w, input logic c);
    @(posedge clk);
    #1;
    addressM  = a;
    outM      = d;
    writeM    = w;
    err_clear = c;
  endtask

  task automatic expect_err(input int off, input logic v, input logic [1:0] c,
                            input logic [15:0] a, input logic [7:0] n, input string tag);
    expect_at(off, S_EVALID, {31'd0, v}, {tag, "_valid"});
    expect_at(off, S_ECODE,  {30'd0, c}, {tag, "_code"});
    expect_at(off, S_EADDR,  {16'd0, a}, {tag, "_addr"});
    expect_at(off, S_ECNT,   {24'd0, n}, {tag, "_count"});
  endtask

  initial begin
    reset        = 1'b0;
    addressM     = 16'h0000;
    outM         = 16'h0000;
    writeM       = 1'b0;
    err_clear    = 1'b0;
    region_rdata = {16'hC2C2, 16'hB1B1, 16'hA0A0};

    // Reset state
    @(posedge clk);
    #1;
    expect_at(0, S_INM, 32'h0, "reset_inM");
    expect_err(0, 1'b0, 2'd0, 16'h0000, 8'd0, "reset_err");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Data RAM write then read
    drive(16'h0005, 16'h1234, 1'b1, 1'b0);
    expect_at(0, S_RWRITE, 32'h1, "ram_wr_strobe");
    expect_at(0, S_RADDR, 32'h5, "ram_wr_addr");
    expect_at(0, S_INV, 32'h0, "ram_wr_valid_addr");
    expect_at(1, S_EVALID, 32'h0, "ram_wr_no_err");
    drive(16'h0005, 16'h0000, 1'b0, 1'b0);
    expect_at(0, S_RWRITE, 32'h0, "ram_rd_no_strobe");
    expect_at(1, S_INM, 32'hA0A0, "ram_rd_data");

    // Screen write, keyboard read
    drive(16'h4010, 16'h00FF, 1'b1, 1'b0);
    expect_at(0, S_RWRITE, 32'h2, "scr_wr_strobe");
    expect_at(0, S_RADDR, 32'h10, "scr_wr_addr");
    expect_at(1, S_INM, 32'hB1B1, "scr_rd_data");
    drive(16'h6000, 16'h0000, 1'b0, 1'b0);
    expect_at(0, S_RADDR, 32'h0, "kbd_rd_addr");
    expect_at(1, S_INM, 32'hC2C2, "kbd_rd_data");
    expect_at(1, S_EVALID, 32'h0, "kbd_rd_no_err");

    // Read-only write
    drive(16'h6000, 16'h0001, 1'b1, 1'b0);
    expect_at(0, S_RWRITE, 32'h0, "kbd_wr_suppressed");
    expect_err(1, 1'b1, 2'd2, 16'h6000, 8'd1, "kbd_wr_err");
    drive(16'h0000, 16'h0000, 1'b0, 1'b1);
    expect_err(1, 1'b0, 2'd0, 16'h0000, 8'd0, "clear1");

    // Unmapped writes, sticky first capture, saturation
    drive(16'h7000, 16'h0001, 1'b1, 1'b0);
    expect_at(0, S_INV, 32'h1, "unmap1_invalid");
    expect_at(0, S_RWRITE, 32'h0, "unmap1_no_strobe");
    expect_at(0, S_RADDR, 32'h0, "unmap1_addr_zero");
    drive(16'h8000, 16'h0002, 1'b1, 1'b0);
    expect_at(0, S_INV, 32'h1, "unmap2_invalid");
    expect_err(1, 1'b1, 2'd1, 16'h7000, 8'd2, "unmap2_err");
    for (int k = 0; k < 300; k++) drive(16'h8000, 16'h0003, 1'b1, 1'b0);
    expect_err(1, 1'b1, 2'd1, 16'h7000, 8'd255, "saturate");
    drive(16'h8000, 16'h0000, 1'b0, 1'b0);
    expect_at(0, S_INV, 32'h1, "unmap_rd_invalid");
    expect_at(1, S_INM, 32'h0, "unmap_rd_zero");
    expect_at(1, S_ECNT, 32'd255, "unmap_rd_not_error");

    // Clear together with a new read-only write, then clear alone
    drive(16'h6000, 16'h0004, 1'b1, 1'b1);
    expect_err(1, 1'b1, 2'd2, 16'h6000, 8'd1, "clear_vs_event");
    drive(16'h0000, 16'h0000, 1'b0, 1'b1);
    expect_err(1, 1'b0, 2'd0, 16'h0000, 8'd0, "clear2");

    // Reset asserted mid-read
    drive(16'h6000, 16'h0005, 1'b1, 1'b0);
    drive(16'h0005, 16'h0000, 1'b0, 1'b0);
    expect_at(0, S_EVALID, 32'h1, "pre_reset_err");
    drive(16'h0005, 16'h0000, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    expect_at(0, S_INM, 32'h0, "mid_reset_inM");
    expect_err(0, 1'b0, 2'd0, 16'h0000, 8'd0, "mid_reset_err");
    drive(16'h0005, 16'h0000, 1'b0, 1'b0);
    reset = 1'b1;
    expect_at(0, S_INM, 32'h0, "post_reset_inM");
    expect_at(1, S_INM, 32'hA0A0, "post_reset_rd");

    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
